img_line_feeder: RTL
====================

Name: img_line_feeder

Overview:
- Synthesizable line-streaming controller that feeds a frame into the image-processing core (line-buffer/convolution top) one line at a time.
- Sends PRIME_LINES lines after start. After that, sends one line per rising edge of the core's line-request interrupt. After the last image line, sends PAD_LINES all-zero lines so the core can flush its final output rows.
- Parametrised in pixel width, image geometry, priming depth and padding depth. Queues interrupt requests so none are lost while a line is in flight.

Parameters:
- PIX_W, 8, pixel width in bits
- IMG_W, 512, pixels per line
- IMG_H, 512, image lines
- PRIME_LINES, 4, lines sent back-to-back after start; must be ≤ IMG_H (elaboration-time check)
- PAD_LINES, 2, zero lines appended after image
- REQ_DEPTH, 3, saturation value of the pending-request counter

Ports:
- axi_clk, in, 1, sole clock, rising edge
- axi_rst, in, 1, synchronous active-low reset
- i_start, in, 1, one-cycle start pulse; ignored unless IDLE
- i_src_data, in, PIX_W, frame source pixel
- i_src_valid, in, 1, source pixel valid
- o_src_ready, out, 1, source pixel accepted when high together with i_src_valid
- o_pix_data, out, PIX_W, pixel to core
- o_pix_valid, out, 1, pixel valid to core
- i_pix_ready, in, 1, core ready
- i_intr, in, 1, core line-request interrupt; level, edge-detected internally
- o_busy, out, 1, high in any state other than IDLE
- o_done, out, 1, one-cycle pulse when the frame is complete
- o_line_cnt, out, $clog2(IMG_H+PAD_LINES+1), lines fully sent in the current frame

Behaviour:
- Reset (axi_rst=0 at a rising edge):
  - state=IDLE
  - all counters, pending count and intr_q cleared
  - o_pix_valid, o_src_ready, o_busy and o_done are 0; o_pix_data is 0; o_line_cnt is 0
- Reset applied mid-operation behaves identically and takes effect on the next edge. The frame is abandoned and no o_done is produced.
- Interrupt edge detection:
  - intr_q is i_intr registered.
  - req_rise = i_intr & ~intr_q.
- Pending counter:
  - +1 on req_rise, −1 when WAIT_REQ consumes a request.
  - If both occur in the same cycle, the count is unchanged.
  - Saturates at REQ_DEPTH; further rises are dropped.
- Pixel path, combinational pass-through:
  - IMG states (PRIME, LINE): o_pix_data=i_src_data, o_pix_valid=i_src_valid, o_src_ready=i_pix_ready.
  - PAD: o_pix_data=0, o_pix_valid=1, o_src_ready=0.
  - All other states: o_pix_valid=0, o_src_ready=0.
- Transfer: a beat completes when o_pix_valid & i_pix_ready.
  - col_cnt counts beats 0..IMG_W−1.
  - On the beat at col_cnt=IMG_W−1, col_cnt returns to 0 and line_cnt increments.
- FSM states and transitions:
  - IDLE: on i_start, go to PRIME and clear counters.
  - PRIME: go to WAIT_REQ once line_cnt reaches PRIME_LINES; go directly to PAD if PRIME_LINES=IMG_H.
  - WAIT_REQ: if pending>0, consume one request, then:
    - go to LINE if line_cnt<IMG_H;
    - else go to PAD if pad lines remain;
    - else go to DONE.
  - LINE: return to WAIT_REQ after completing one line.
  - PAD: return to WAIT_REQ after one line; if PAD_LINES=0, this step is skipped and the FSM goes to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Interrupts arriving during PRIME, LINE or PAD are queued, not lost.
- Latency: zero cycles from source to core. The first beat can complete in the cycle after the start edge.
- o_line_cnt counts both image and pad lines.

Optional Feature:
- Macro FEED_STATS_EN.
- Defined:
  - adds output o_stall_cnt (32 bit, saturating): counts cycles with o_pix_valid=1 and i_pix_ready=0;
  - adds output o_req_ovf (1 bit, sticky): set when a req_rise is dropped at saturation;
  - both are cleared by reset and by i_start.
- Undefined: neither port nor its logic exists; core behaviour is identical.

Decomposition:
- Package img_feed_pkg:
  - FSM state enum (IDLE, PRIME, WAIT_REQ, LINE, PAD, DONE);
  - width helper function for the counters.
- Sub-module img_req_queue: edge detector plus saturating pending counter, with the consume input, the pending>0 output and the overflow output.

Test Plan:
All scenarios use IMG_W=4, IMG_H=6, PRIME_LINES=2, PAD_LINES=2, source always valid with an incrementing pattern 1,2,3,…
1. Reset check: hold axi_rst=0 with i_start=1 and i_intr toggling -> every output stays 0 and o_busy=0.
2. Priming and stall: start with sink always ready -> 8 beats on 8 consecutive cycles carrying data 1..8, o_line_cnt=2; then o_pix_valid=0 indefinitely while no i_intr is given.
3. Full frame: issue 6 i_intr pulses, one after each line completes -> 4 more image lines (data 9..24), then 2 lines of zeros. o_done pulses once, 32 beats in total, final o_line_cnt=8, then IDLE.
4. Back-pressure: i_pix_ready toggled pseudo-randomly -> the data sequence at the core exactly matches the source order with no loss or duplication. With FEED_STATS_EN, o_stall_cnt equals the number of ready-low cycles while valid was high.
5. Queued requests: 4 i_intr pulses during one LINE -> 3 queued lines sent with only the WAIT_REQ consume-cycle gap between them; the 4th pulse is dropped and, with FEED_STATS_EN, o_req_ovf=1.
6. Mid-frame reset: apply reset at the second beat of a LINE -> next cycle IDLE, o_line_cnt=0, no o_done; a restart with i_start reproduces scenario 2 exactly.

Source files
------------

// File: rtl/img_feed_pkg.sv
// Shared state encoding and counter sizing helper for the image line feeder.
package img_feed_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StWaitReq,
    StLine,
    StPad,
    StDone
  } feed_state_e;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/img_req_queue.sv
// Line-request queue: rising-edge detect on the core interrupt feeding a
// saturating pending counter that the feeder drains one request at a time.
module img_req_queue import img_feed_pkg::*; #(
  parameter int unsigned Depth = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic intr_i,
  input  logic consume_i,
  input  logic clr_i,
  output logic pending_o,
  output logic drop_o
);

  localparam int unsigned CntW = cnt_w(Depth);
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);

  logic            intr_q;
  logic            rise;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign rise = intr_i & ~intr_q;

  // A rise and a consume in the same cycle cancel out.
  always_comb begin
    cnt_d  = cnt_q;
    drop_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (rise && !consume_i) begin
      if (cnt_q == CntMax) begin
        drop_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (consume_i && !rise && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      intr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      intr_q <= intr_i;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/img_line_feeder.sv
// Streams a frame into the image core line by line, gated by its line-request interrupt.
// Optional FEED_STATS_EN adds a stall-cycle counter and a sticky request-overflow flag.
module img_line_feeder import img_feed_pkg::*; #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned IMG_W       = 512,
  parameter int unsigned IMG_H       = 512,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned PAD_LINES   = 2,
  parameter int unsigned REQ_DEPTH   = 3
) (
  input  logic                                axi_clk,
  input  logic                                axi_rst,
  input  logic                                i_start,
  input  logic [PIX_W-1:0]                    i_src_data,
  input  logic                                i_src_valid,
  output logic                                o_src_ready,
  output logic [PIX_W-1:0]                    o_pix_data,
  output logic                                o_pix_valid,
  input  logic                                i_pix_ready,
  input  logic                                i_intr,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [cnt_w(IMG_H+PAD_LINES)-1:0]   o_line_cnt
`ifdef FEED_STATS_EN
  ,
  output logic [31:0]                         o_stall_cnt,
  output logic                                o_req_ovf
`endif
);

  localparam int unsigned LineW = cnt_w(IMG_H + PAD_LINES);
  localparam int unsigned ColW  = cnt_w(IMG_W - 1);

  localparam logic [ColW-1:0]  ColLast  = ColW'(IMG_W - 1);
  localparam logic [LineW-1:0] PrimeEnd = LineW'(PRIME_LINES);
  localparam logic [LineW-1:0] ImgEnd   = LineW'(IMG_H);
  localparam logic [LineW-1:0] FrameEnd = LineW'(IMG_H + PAD_LINES);

  if (PRIME_LINES > IMG_H) begin : g_prime_check
    $error("img_line_feeder: PRIME_LINES must not exceed IMG_H");
  end

  feed_state_e      state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [LineW-1:0] line_q, line_d;
  logic             line_end;
  logic             consume;
  logic             start_clr;
  logic             req_pending;
  logic             req_drop;

  img_req_queue #(
    .Depth (REQ_DEPTH)
  ) u_req_queue (
    .clk_i     (axi_clk),
    .rst_ni    (axi_rst),
    .intr_i    (i_intr),
    .consume_i (consume),
    .clr_i     (start_clr),
    .pending_o (req_pending),
    .drop_o    (req_drop)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    line_end    = 1'b0;
    consume     = 1'b0;
    start_clr   = 1'b0;
    o_pix_data  = '0;
    o_pix_valid = 1'b0;
    o_src_ready = 1'b0;
    o_done      = 1'b0;

    if (state_q inside {StPrime, StLine}) begin
      o_pix_data  = i_src_data;
      o_pix_valid = i_src_valid;
      o_src_ready = i_pix_ready;
    end else if (state_q == StPad) begin
      o_pix_valid = 1'b1;
    end

    if (o_pix_valid && i_pix_ready) begin
      if (col_q == ColLast) begin
        col_d    = '0;
        line_d   = line_q + LineW'(1);
        line_end = 1'b1;
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          start_clr = 1'b1;
          col_d     = '0;
          line_d    = '0;
          state_d   = (PRIME_LINES == 0) ? StWaitReq : StPrime;
        end
      end
      StPrime: begin
        if (line_end && line_d == PrimeEnd) begin
          if (PRIME_LINES < IMG_H) state_d = StWaitReq;
          else if (PAD_LINES > 0)  state_d = StPad;
          else                     state_d = StDone;
        end
      end
      StWaitReq: begin
        if (req_pending) begin
          consume = 1'b1;
          if (line_q < ImgEnd)        state_d = StLine;
          else if (line_q < FrameEnd) state_d = StPad;
          else                        state_d = StDone;
        end
      end
      // The final line of the frame finishes it without waiting for another request.
      StLine: begin
        if (line_end) begin
          state_d = (line_d == ImgEnd && PAD_LINES == 0) ? StDone : StWaitReq;
        end
      end
      StPad: begin
        if (line_end) begin
          state_d = (line_d == FrameEnd) ? StDone : StWaitReq;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_line_cnt = line_q;

`ifdef FEED_STATS_EN
  logic [31:0] stall_q;
  logic        ovf_q;

  always_ff @(posedge axi_clk) begin
    if (!axi_rst || start_clr) begin
      stall_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (o_pix_valid && !i_pix_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (req_drop) ovf_q <= 1'b1;
    end
  end

  assign o_stall_cnt = stall_q;
  assign o_req_ovf   = ovf_q;
`else
  logic unused_req_drop;
  assign unused_req_drop = req_drop;
`endif

endmodule
